// File: rtl/vga_fb_access_arbiter.sv
// rtl/vga_fb_access_arbiter.sv - single-port frame-buffer scheduler: display fetch first, writer in free slots
// Define FB_CLEAR_EN to add a hardware fill of the whole frame buffer (clear_req/clear_color/clear_busy).
module vga_fb_access_arbiter #(
  parameter int H_VISIBLE_AREA = 640,
  parameter int V_VISIBLE_AREA = 480,
  parameter int H_TOTAL        = 800,
  parameter int V_TOTAL        = 525,
  parameter int FB_WIDTH       = 160,
  parameter int ADDR_W         = 15,
  parameter int DATA_W         = 8
) (
  input  logic              clk_25,
  input  logic              rst_n,
  input  logic [10:0]       h_count,
  input  logic [10:0]       v_count,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        red_8bit,
  output logic [7:0]        green_8bit,
  output logic [7:0]        blue_8bit,
`ifdef FB_CLEAR_EN
  input  logic              clear_req,
  input  logic [DATA_W-1:0] clear_color,
  output logic              clear_busy,
`endif
  output logic              frame_start
);

  localparam logic [10:0] H_VIS = 11'(H_VISIBLE_AREA);
  localparam logic [10:0] V_VIS = 11'(V_VISIBLE_AREA);
  localparam logic [10:0] H_TOT = 11'(H_TOTAL);
  localparam logic [10:0] V_TOT = 11'(V_TOTAL);

  logic [10:0]       h_plus, v_plus, la_h, la_v;
  logic              vis_la, read_slot;
  logic [ADDR_W-1:0] row_w, col_w, rd_addr;

  // Fetch 3 clocks ahead so RAM latency plus pixel register lands exactly on the counters.
  always_comb begin
    h_plus = h_count + 11'd3;
    v_plus = v_count + 11'd1;
    la_h   = h_count + 11'd3;
    la_v   = v_count;
    if (h_plus >= H_TOT) begin
      la_h = h_plus - H_TOT;
      la_v = (v_plus == V_TOT) ? 11'd0 : v_plus;
    end
    vis_la    = (la_h < H_VIS) && (la_v < V_VIS);
    read_slot = vis_la && (la_h[1:0] == 2'b00);
    row_w     = ADDR_W'(la_v >> 2);
    col_w     = ADDR_W'(la_h >> 2);
    rd_addr   = (row_w << 7) + (row_w << 5) + col_w;
  end

  logic              clear_idle, clr_wr;
  logic [ADDR_W-1:0] clr_waddr;
  logic [DATA_W-1:0] clr_wdata;

`ifdef FB_CLEAR_EN
  localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_WIDTH * 120 - 1);

  typedef enum logic {S_IDLE, S_CLEAR} clr_state_t;
  clr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [DATA_W-1:0] clr_color_q, clr_color_d;

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      clr_addr_q  <= '0;
      clr_color_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      clr_color_q <= clr_color_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    clr_color_d = clr_color_q;
    case (state_q)
      S_IDLE: if (clear_req) begin
        state_d     = S_CLEAR;
        clr_addr_d  = '0;
        clr_color_d = clear_color;
      end
      S_CLEAR: if (!read_slot) begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == FB_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    clear_busy = (state_q == S_CLEAR);
    clear_idle = !clear_busy;
    clr_wr     = clear_busy && !read_slot;
    clr_waddr  = clr_addr_q;
    clr_wdata  = clr_color_q;
  end
`else
  assign clear_idle = 1'b1;
  assign clr_wr     = 1'b0;
  assign clr_waddr  = '0;
  assign clr_wdata  = '0;
`endif

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]        vis_q, vis_d;
  logic [1:0]        rd_q, rd_d;
  logic [7:0]        pix_q, pix_d;
  logic              frame_start_q, frame_start_d;

  // rst_n gates ready so an asserted reset silences the handshake immediately.
  assign wr_ready = rst_n && !read_slot && clear_idle;

  always_comb begin
    mem_addr_d    = mem_addr_q;
    mem_we_d      = 1'b0;
    mem_wdata_d   = mem_wdata_q;
    if (read_slot) begin
      mem_addr_d = rd_addr;
    end else if (clr_wr) begin
      mem_addr_d  = clr_waddr;
      mem_wdata_d = clr_wdata;
      mem_we_d    = 1'b1;
    end else if (wr_valid && wr_ready) begin
      mem_addr_d  = wr_addr;
      mem_wdata_d = wr_data;
      mem_we_d    = 1'b1;
    end
    vis_d         = {vis_q[1:0], vis_la};
    rd_d          = {rd_q[0], read_slot};
    pix_d         = rd_q[1] ? mem_rdata : pix_q;
    frame_start_d = (h_count == 11'd0) && (v_count == 11'd0);
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= '0;
      vis_q         <= '0;
      rd_q          <= '0;
      pix_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      vis_q         <= vis_d;
      rd_q          <= rd_d;
      pix_q         <= pix_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    mem_addr    = mem_addr_q;
    mem_we      = mem_we_q;
    mem_wdata   = mem_wdata_q;
    frame_start = frame_start_q;
    red_8bit    = 8'd0;
    green_8bit  = 8'd0;
    blue_8bit   = 8'd0;
    if (vis_q[2]) begin
      red_8bit   = {pix_q[7:5], pix_q[7:5], pix_q[7:6]};
      green_8bit = {pix_q[4:2], pix_q[4:2], pix_q[4:3]};
      blue_8bit  = {pix_q[1:0], pix_q[1:0], pix_q[1:0], pix_q[1:0]};
    end
  end

endmodule

// File: tb/tb_vga_fb_access_arbiter.sv
// tb/tb_vga_fb_access_arbiter.sv - scoreboard bench for vga_fb_access_arbiter (default build)
module tb_vga_fb_access_arbiter;

  typedef struct {
    logic [14:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk_25 = 1'b0;
  logic        rst_n;
  logic [10:0] h_count, v_count;
  logic        wr_valid, wr_ready;
  logic [14:0] wr_addr, mem_addr;
  logic [7:0]  wr_data, mem_wdata, mem_rdata;
  logic        mem_we, frame_start;
  logic [7:0]  red_8bit, green_8bit, blue_8bit;

  vga_fb_access_arbiter dut (
    .clk_25     (clk_25),
    .rst_n      (rst_n),
    .h_count    (h_count),
    .v_count    (v_count),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .red_8bit   (red_8bit),
    .green_8bit (green_8bit),
    .blue_8bit  (blue_8bit),
    .frame_start(frame_start)
  );

  always #20 clk_25 = ~clk_25;

  function automatic logic [7:0] pat(input int i);
    pat = (i == 0) ? 8'hE0 : 8'(i * 37 + 5);
  endfunction

  logic [7:0] ram [0:32767];
  bit         ram_loaded;

  always @(posedge clk_25) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 32768; i++) ram[i] <= pat(i);
      ram_loaded <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  logic [7:0] ref_ram [0:32767];
  wr_t        wq[$];
  wr_t        sb[$];
  int         n_cmp, n_mis;
  int         cur_h, cur_v, prev_h, prev_v;
  int         since_rst, run, nacc;
  logic       prev_acc, prev_rd, rgb_chk;
  logic [14:0] prev_rd_addr;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // bit 15 = read slot, bits 14:0 = fetch address
  function automatic logic [15:0] model_rd(input int h, input int v);
    int lh, lv;
    lh = h + 3;
    lv = v;
    if (lh >= 800) begin
      lh -= 800;
      lv = (v == 524) ? 0 : v + 1;
    end
    model_rd = {1'b0, 15'((lv / 4) * 160 + lh / 4)};
    if (lh < 640 && lv < 480 && lh % 4 == 0) model_rd[15] = 1'b1;
  endfunction

  function automatic logic [23:0] exp_rgb(input int h, input int v);
    logic [7:0] p;
    if (h >= 640 || v >= 480) return 24'd0;
    p = ref_ram[(v / 4) * 160 + h / 4];
    return {p[7:5], p[7:5], p[7:6], p[4:2], p[4:2], p[4:3], p[1:0], p[1:0], p[1:0], p[1:0]};
  endfunction

  task automatic step();
    logic [15:0] rd;
    logic        acc;
    wr_t         e;
    @(posedge clk_25);
    #1;
    h_count  = 11'(cur_h);
    v_count  = 11'(cur_v);
    wr_valid = (wq.size() > 0);
    if (wr_valid) begin
      wr_addr = wq[0].addr;
      wr_data = wq[0].data;
    end
    #1;
    rd = model_rd(cur_h, cur_v);
    if (since_rst > 0) begin
      if (prev_rd) check_eq("rd_addr", 32'(mem_addr), 32'(prev_rd_addr));
      check_eq("mem_we", 32'(mem_we), 32'(prev_acc));
      if (mem_we && sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("wr_addr", 32'(mem_addr), 32'(e.addr));
        check_eq("wr_data", 32'(mem_wdata), 32'(e.data));
      end
      check_eq("frame_start", 32'(frame_start), 32'(prev_h == 0 && prev_v == 0));
    end
    check_eq("wr_ready", 32'(wr_ready), 32'(!rd[15]));
    if (rgb_chk && run >= 8)
      check_eq("rgb", 32'({red_8bit, green_8bit, blue_8bit}), 32'(exp_rgb(cur_h, cur_v)));
    acc = wr_valid && !rd[15];
    if (acc) begin
      sb.push_back(wq[0]);
      ref_ram[wq[0].addr] = wq[0].data;
      void'(wq.pop_front());
      nacc++;
    end
    prev_acc     = acc;
    prev_rd      = rd[15];
    prev_rd_addr = rd[14:0];
    prev_h       = cur_h;
    prev_v       = cur_v;
    since_rst++;
    run++;
  endtask

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      cur_h++;
      if (cur_h == 800) begin
        cur_h = 0;
        cur_v = (cur_v == 524) ? 0 : cur_v + 1;
      end
    end
  endtask

  task automatic jump(input int h, input int v);
    cur_h = h;
    cur_v = v;
    run   = 0;
  endtask

  initial begin
    int base;
    for (int i = 0; i < 32768; i++) ref_ram[i] = pat(i);
    rst_n = 1'b0; h_count = '0; v_count = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rgb_chk = 1'b0; prev_acc = 1'b0; prev_rd = 1'b0; prev_rd_addr = '0;
    since_rst = 0; run = 0; nacc = 0; prev_h = 0; prev_v = 0;
    repeat (3) @(posedge clk_25);
    #1;
    check_eq("reset_we", 32'(mem_we), 32'd0);
    check_eq("reset_ready", 32'(wr_ready), 32'd0);
    check_eq("reset_rgb", 32'({red_8bit, green_8bit, blue_8bit}), 32'd0);
    check_eq("reset_fs", 32'(frame_start), 32'd0);
    check_eq("reset_addr", 32'(mem_addr), 32'd0);
    @(posedge clk_25);
    #1 rst_n = 1'b1;

    // first visible line of a frame, word 0 = 0xE0, past h=640
    rgb_chk = 1'b1;
    jump(790, 524);
    advance(680);

    // row 0 -> row 1 transition across v=3/4
    jump(790, 2);
    advance(830);

    // writer colliding with a read slot, then continuous visible-line writes
    rgb_chk = 1'b0;
    wq.push_back('{addr: 15'h0100, data: 8'h1C});
    for (int i = 0; i < 39; i++) wq.push_back('{addr: 15'(16'h4000 + i), data: 8'(i)});
    jump(101, 10);
    base = nacc;
    advance(40);
    check_eq("bw_accepts", 32'(nacc - base), 32'd30);
    advance(20);

    // blanking: everything but the read slots is writable
    for (int i = 0; i < 120; i++) wq.push_back('{addr: 15'(16'h5000 + i), data: 8'(i ^ 8'h5A)});
    jump(650, 20);
    advance(170);

    // reset while a write is on the bus; write goes to an undisplayed address
    rgb_chk = 1'b1;
    jump(200, 40);
    advance(12);
    wq.push_back('{addr: 15'h7000, data: 8'h55});
    for (int i = 0; i < 8 && !mem_we; i++) advance(1);
    check_eq("abort_we_seen", 32'(mem_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("abort_we", 32'(mem_we), 32'd0);
    check_eq("abort_rgb", 32'({red_8bit, green_8bit, blue_8bit}), 32'd0);
    check_eq("abort_ready", 32'(wr_ready), 32'd0);
    repeat (3) @(posedge clk_25);
    #1 rst_n = 1'b1;
    since_rst = 0;
    run = 0;
    prev_acc = 1'b0;
    advance(60);

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    check_eq("wq_empty", 32'(wq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
